alu_islem_birimi: RTL and testbench

Sequential ALU front-end that accepts an operand pair and opcode over a valid/ready handshake, computes the result (single-cycle logic/arithmetic ops, multi-cycle shift-add multiply), and holds it on a registered valid/ready output. It sits directly upstream of the bit-level 2:1 result-select muxes. It consumes the operands and produces the registered result word that those muxes and the downstream display logic select from.

---
 rtl/alu_islem_birimi_pkg.sv | 22 ++
 rtl/alu_islem_birimi_carpici.sv | 59 +++++
 rtl/alu_islem_birimi.sv | 133 +++++++++++++
 tb/tb_alu_islem_birimi.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_islem_birimi_pkg.sv
// Shared constants for alu_islem_birimi: opcodes, FSM encoding and default width.
// The HESAP state only exists when ALU_MUL_EN is defined.
package alu_paket;

   localparam int unsigned VARSAYILAN_WIDTH = 4;

   localparam logic [2:0] ISLEM_ADD  = 3'b000;
   localparam logic [2:0] ISLEM_SUB  = 3'b001;
   localparam logic [2:0] ISLEM_AND  = 3'b010;
   localparam logic [2:0] ISLEM_OR   = 3'b011;
   localparam logic [2:0] ISLEM_XOR  = 3'b100;
   localparam logic [2:0] ISLEM_SHL  = 3'b101;
   localparam logic [2:0] ISLEM_MUL  = 3'b110;
   localparam logic [2:0] ISLEM_PASS = 3'b111;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {BOS = 2'd0, HESAP = 2'd1, SONUC = 2'd2} durum_e;
`else
   typedef enum logic [1:0] {BOS = 2'd0, SONUC = 2'd2} durum_e;
`endif

endpackage

// File: rtl/alu_islem_birimi_carpici.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
// baslat loads the operands; bitti is high whenever the counter is zero.
module alu_carpici
   import alu_paket::*;
#(
   parameter int unsigned WIDTH = VARSAYILAN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baslat,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 bitti,
   output logic [2*WIDTH-1:0]   carpim
);

   localparam int unsigned SW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] carpilan_q, carpilan_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   carpan_q, carpan_d;
   logic [SW-1:0]      sayac_q, sayac_d;

   always_comb begin
      carpilan_d = carpilan_q;
      acc_d      = acc_q;
      carpan_d   = carpan_q;
      sayac_d    = sayac_q;
      if (baslat) begin
         carpilan_d = {{WIDTH{1'b0}}, a};
         carpan_d   = b;
         acc_d      = '0;
         sayac_d    = SW'(WIDTH);
      end else if (sayac_q != '0) begin
         if (carpan_q[0]) acc_d = acc_q + carpilan_q;
         carpilan_d = carpilan_q << 1;
         carpan_d   = carpan_q >> 1;
         sayac_d    = sayac_q - SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carpilan_q <= '0;
         acc_q      <= '0;
         carpan_q   <= '0;
         sayac_q    <= '0;
      end else begin
         carpilan_q <= carpilan_d;
         acc_q      <= acc_d;
         carpan_q   <= carpan_d;
         sayac_q    <= sayac_d;
      end
   end

   assign bitti  = (sayac_q == '0);
   assign carpim = acc_q;

endmodule

// File: rtl/alu_islem_birimi.sv
// ALU front-end: valid/ready request in, registered result held until taken.
// Define ALU_MUL_EN to build the multi-cycle multiplier (opcode 110); otherwise 110 reports hata.
module alu_islem_birimi
   import alu_paket::*;
#(
   parameter int unsigned WIDTH = VARSAYILAN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2:0]           islem,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   sonuc,
   output logic                 sifir,
   output logic                 hata
);

   localparam int unsigned RW = 2 * WIDTH;

   durum_e          durum_q, durum_d;
   logic [RW-1:0]   sonuc_q, sonuc_d;
   logic            sifir_q, sifir_d;
   logic            hata_q, hata_d;

   logic [RW-1:0]   hesap_sonuc;
   logic            hesap_hata;
   logic [WIDTH:0]  toplam, fark;
   logic [WIDTH+2:0] kaydirma;

`ifdef ALU_MUL_EN
   logic            carp_baslat, carp_bitti;
   logic [RW-1:0]   carp_sonuc;

   alu_carpici #(.WIDTH(WIDTH)) u_carpici (
      .clk    (clk),
      .rst    (rst),
      .baslat (carp_baslat),
      .a      (A),
      .b      (B),
      .bitti  (carp_bitti),
      .carpim (carp_sonuc)
   );
`endif

   // Bit WIDTH of the subtraction is the borrow, i.e. A < B.
   always_comb begin
      toplam      = {1'b0, A} + {1'b0, B};
      fark        = {1'b0, A} - {1'b0, B};
      kaydirma    = {3'b000, A} << B[1:0];
      hesap_sonuc = '0;
      hesap_hata  = 1'b0;
      case (islem)
         ISLEM_ADD:  hesap_sonuc = RW'(toplam);
         ISLEM_SUB:  hesap_sonuc = RW'(fark);
         ISLEM_AND:  hesap_sonuc = RW'(A & B);
         ISLEM_OR:   hesap_sonuc = RW'(A | B);
         ISLEM_XOR:  hesap_sonuc = RW'(A ^ B);
         ISLEM_SHL:  hesap_sonuc = RW'(kaydirma);
`ifndef ALU_MUL_EN
         ISLEM_MUL:  hesap_hata  = 1'b1;
`endif
         ISLEM_PASS: hesap_sonuc = RW'(A);
         default: ;
      endcase
   end

   always_comb begin
      durum_d = durum_q;
      sonuc_d = sonuc_q;
      sifir_d = sifir_q;
      hata_d  = hata_q;
`ifdef ALU_MUL_EN
      carp_baslat = 1'b0;
`endif
      unique case (durum_q)
         BOS: begin
            if (in_valid) begin
`ifdef ALU_MUL_EN
               if (islem == ISLEM_MUL) begin
                  carp_baslat = 1'b1;
                  durum_d     = HESAP;
               end else
`endif
               begin
                  durum_d = SONUC;
                  sonuc_d = hesap_sonuc;
                  sifir_d = (hesap_sonuc == '0);
                  hata_d  = hesap_hata;
               end
            end
         end
`ifdef ALU_MUL_EN
         HESAP: begin
            if (carp_bitti) begin
               durum_d = SONUC;
               sonuc_d = carp_sonuc;
               sifir_d = (carp_sonuc == '0);
               hata_d  = 1'b0;
            end
         end
`endif
         SONUC: begin
            if (out_ready) durum_d = BOS;
         end
         default: durum_d = BOS;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         durum_q <= BOS;
         sonuc_q <= '0;
         sifir_q <= 1'b0;
         hata_q  <= 1'b0;
      end else begin
         durum_q <= durum_d;
         sonuc_q <= sonuc_d;
         sifir_q <= sifir_d;
         hata_q  <= hata_d;
      end
   end

   assign in_ready  = (durum_q == BOS);
   assign out_valid = (durum_q == SONUC);
   assign sonuc     = sonuc_q;
   assign sifir     = sifir_q;
   assign hata      = hata_q;

endmodule

// File: tb/tb_alu_islem_birimi.sv
// Directed-vector bench for alu_islem_birimi (WIDTH=4); expectations follow ALU_MUL_EN.
module tb_alu_islem_birimi;
   import alu_paket::*;

   localparam int unsigned W = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   A = '0;
   logic [W-1:0]   B = '0;
   logic [2:0]     islem = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] sonuc;
   logic           sifir;
   logic           hata;

   int unsigned kontrol_sayisi = 0;
   int unsigned hata_sayisi = 0;

   always #5 clk = ~clk;

   alu_islem_birimi #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .islem     (islem),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sonuc     (sonuc),
      .sifir     (sifir),
      .hata      (hata)
   );

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
      kontrol_sayisi++;
      if (gozlenen !== beklenen) begin
         hata_sayisi++;
         $display("FAIL %s: gozlenen=0x%0h beklenen=0x%0h", etiket, gozlenen, beklenen);
      end
   endtask

   task automatic cikis_kontrol(input string on, input logic rdy, input logic ov,
                                input logic [7:0] s, input logic z, input logic e);
      kontrol({on, "_in_ready"},  32'(in_ready),  32'(rdy));
      kontrol({on, "_out_valid"}, 32'(out_valid), 32'(ov));
      kontrol({on, "_sonuc"},     32'(sonuc),     32'(s));
      kontrol({on, "_sifir"},     32'(sifir),     32'(z));
      kontrol({on, "_hata"},      32'(hata),      32'(e));
   endtask

   // Presents one request in BOS; returns 1 ns after the accepting edge.
   task automatic gonder(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      @(negedge clk);
      A = a; B = b; islem = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Takes the held result with a one-cycle out_ready pulse.
   task automatic birak(input string on);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      kontrol({on, "_birak_out_valid"}, 32'(out_valid), 32'd0);
      kontrol({on, "_birak_in_ready"},  32'(in_ready),  32'd1);
   endtask

   logic [3:0] ta [4] = '{4'h5, 4'hF, 4'hF, 4'h9};
   logic [3:0] tb [4] = '{4'hA, 4'h3, 4'h7, 4'h0};
   logic [2:0] top [4] = '{ISLEM_OR, ISLEM_XOR, ISLEM_SHL, ISLEM_PASS};
   logic [7:0] tbek [4] = '{8'h0F, 8'h0C, 8'h78, 8'h09};

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cikis_kontrol("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      gonder(4'd9, 4'd8, ISLEM_ADD);
      cikis_kontrol("add", 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
      birak("add");
      kontrol("add_sonuc_korunur", 32'(sonuc), 32'h11);

      gonder(4'd3, 4'd5, ISLEM_SUB);
      cikis_kontrol("sub", 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0);
      birak("sub");

      gonder(4'h5, 4'hA, ISLEM_AND);
      cikis_kontrol("and", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      birak("and");

      gonder(4'hC, 4'h3, ISLEM_OR);
      cikis_kontrol("or", 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         A = 4'd1; B = 4'd1; islem = ISLEM_ADD; in_valid = 1'b1;
         @(posedge clk); #1;
         cikis_kontrol("geri_basinc", 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      birak("geri_basinc");
      gonder(4'd1, 4'd1, ISLEM_ADD);
      cikis_kontrol("geri_basinc_sonra", 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
      birak("geri_basinc_sonra");

`ifdef ALU_MUL_EN
      gonder(4'hF, 4'hF, ISLEM_MUL);
      cikis_kontrol("mul_kabul", 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         kontrol("mul_bekle_out_valid", 32'(out_valid), 32'd0);
         kontrol("mul_bekle_in_ready",  32'(in_ready),  32'd0);
      end
      @(posedge clk); #1;
      cikis_kontrol("mul", 1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
      birak("mul");
`else
      gonder(4'hF, 4'hF, ISLEM_MUL);
      cikis_kontrol("mul_kapali", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      birak("mul_kapali");
`endif

      gonder(4'd7, 4'd6, ISLEM_MUL);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      cikis_kontrol("reset_mul", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      gonder(4'd1, 4'd1, ISLEM_ADD);
      cikis_kontrol("reset_sonra_add", 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
      birak("reset_sonra_add");

      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         kontrol("ardisik_bos_in_ready",  32'(in_ready),  32'd1);
         kontrol("ardisik_bos_out_valid", 32'(out_valid), 32'd0);
         A = ta[k]; B = tb[k]; islem = top[k]; in_valid = 1'b1;
         @(negedge clk);
         cikis_kontrol("ardisik", 1'b0, 1'b1, tbek[k], 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      kontrol("ardisik_son_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL zaman_asimi: gozlenen=bitmedi beklenen=bitti");
      $fatal(1);
   end

endmodule
